// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: FSM states, latch op encodings and counter sizing for sr_latch_ctrl
package sr_latch_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sr_latch_ctrl_sync2.sv
// sync2: two-flop synchronizer for one asynchronous latch feedback bit
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m <= 1'b0;
            q <= 1'b0;
        end else begin
            m <= d;
            q <= m;
        end
endmodule

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin shared NAND SR latch sequencer; SR_LATCH_CTRL_SKIP_REDUNDANT_EN skips pulses already satisfied
module sr_latch_ctrl
    import sr_latch_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    output logic [NREQ-1:0] ack,
    output logic            err,
    output logic            err_sticky,
    output logic            busy,
    output logic            s_n,
    output logic            r_n,
    input  logic            q_fb,
    input  logic            qbar_fb
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = cnt_w(PULSE_CYC > SETTLE_CYC ? PULSE_CYC : SETTLE_CYC);

    state_t          state, state_d;
    logic [IW-1:0]   rr, rr_d, grant, grant_d, pick;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] ack_d;
    logic            op_r, op_d, err_d, q_s, qb_s, hit, pass;

    sync2 u_sync_q  (.clk(clk), .rst_n(rst_n), .d(q_fb),    .q(q_s));
    sync2 u_sync_qb (.clk(clk), .rst_n(rst_n), .d(qbar_fb), .q(qb_s));

    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int i = 0; i < NREQ; i++)
            if (!hit && req[(int'(rr) + i) % NREQ]) begin
                hit  = 1'b1;
                pick = IW'((int'(rr) + i) % NREQ);
            end
    end

    assign pass = (q_s == op_r) && (qb_s == ~op_r);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant_d = grant;
        op_d    = op_r;
        rr_d    = rr;
        ack_d   = '0;
        err_d   = 1'b0;
        case (state)
            IDLE:
                if (hit) begin
                    grant_d = pick;
                    op_d    = op[pick];
                    cnt_d   = '0;
`ifdef SR_LATCH_CTRL_SKIP_REDUNDANT_EN
                    state_d = (q_s == op[pick] && qb_s == ~op[pick]) ? CHECK : PULSE;
`else
                    state_d = PULSE;
`endif
                end
            PULSE: begin
                cnt_d   = (cnt == CW'(PULSE_CYC - 1)) ? '0 : cnt + 1'b1;
                state_d = (cnt == CW'(PULSE_CYC - 1)) ? SETTLE : PULSE;
            end
            SETTLE: begin
                cnt_d   = (cnt == CW'(SETTLE_CYC - 1)) ? '0 : cnt + 1'b1;
                state_d = (cnt == CW'(SETTLE_CYC - 1)) ? CHECK : SETTLE;
            end
            CHECK: begin
                state_d      = IDLE;
                ack_d[grant] = 1'b1;
                err_d        = !pass;
                rr_d         = IW'((int'(grant) + 1) % NREQ);
            end
            default: state_d = IDLE;
        endcase
    end

    // latch drives come from the next state so only one of s_n/r_n can ever be low
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= '0;
            op_r       <= OP_CLR;
            rr         <= '0;
            ack        <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            busy       <= 1'b0;
            s_n        <= 1'b1;
            r_n        <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            grant      <= grant_d;
            op_r       <= op_d;
            rr         <= rr_d;
            ack        <= ack_d;
            err        <= err_d;
            err_sticky <= err_sticky | err_d;
            busy       <= state_d != IDLE;
            s_n        <= !(state_d == PULSE && op_d == OP_SET);
            r_n        <= !(state_d == PULSE && op_d == OP_CLR);
        end
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed scoreboard bench for sr_latch_ctrl with a gate-delay NAND latch model
module tb_sr_latch_ctrl;
    typedef struct packed {
        logic [1:0] ack;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] req = '0, op = '0, ack;
    logic       err, err_sticky, busy, s_n, r_n, q_fb, qbar_fb;
    logic       lq = 1'b0, lqb = 1'b1, stuck = 1'b0;
    int         cyc = 0, checks = 0, failures = 0;
    exp_t       sb[$];

    sr_latch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .ack(ack), .err(err),
        .err_sticky(err_sticky), .busy(busy), .s_n(s_n), .r_n(r_n),
        .q_fb(q_fb), .qbar_fb(qbar_fb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge s_n) begin #2 lq = 1'b1; #2 lqb = 1'b0; end
    always @(negedge r_n) begin #2 lqb = 1'b1; #2 lq = 1'b0; end
    assign q_fb    = stuck ? 1'b0 : lq;
    assign qbar_fb = lqb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) chk("never_both_low", {31'd0, s_n | r_n}, 32'd1);

    task automatic push(input logic [1:0] a, input logic e, input int lat);
        sb.push_back(exp_t'{ack: a, err: e, cyc: cyc + 1 + lat});
    endtask

    task automatic wait_ack(input int budget);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                got = 1'b1;
                chk("sb_nonempty", sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ack_value", ack, e.ack);
                    chk("err_value", err, e.err);
                    chk("ack_cycle", cyc, e.cyc);
                end
                req = req & ~ack;
            end
        end
        chk("ack_seen", got, 1);
    endtask

    localparam int RED_LAT =
`ifdef SR_LATCH_CTRL_SKIP_REDUNDANT_EN
        1;
`else
        6;
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_s_n", s_n, 1);
        chk("rst_r_n", r_n, 1);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        req = 2'b01; op = 2'b01; push(2'b01, 1'b0, 6);
        @(negedge clk); chk("set_s_n_e0", s_n, 0); chk("set_busy", busy, 1); chk("set_r_n", r_n, 1);
        @(negedge clk); chk("set_s_n_e1", s_n, 0);
        @(negedge clk); chk("set_s_n_e2", s_n, 1);
        wait_ack(20);
        chk("set_q", q_fb, 1);
        @(negedge clk); chk("ack_one_cycle", ack, 0); chk("idle_busy", busy, 0);

        req = 2'b10; op = 2'b00; push(2'b10, 1'b0, 6);
        @(negedge clk); chk("clr_r_n_e0", r_n, 0); chk("clr_s_n", s_n, 1);
        @(negedge clk); chk("clr_r_n_e1", r_n, 0);
        @(negedge clk); chk("clr_r_n_e2", r_n, 1);
        wait_ack(20);
        chk("clr_q", q_fb, 0);
        chk("clr_qbar", qbar_fb, 1);
        @(negedge clk);

        req = 2'b11; op = 2'b01; push(2'b01, 1'b0, 6); push(2'b10, 1'b0, 13);
        wait_ack(20);
        wait_ack(20);
        chk("cont1_q", q_fb, 0);
        @(negedge clk);
        req = 2'b11; op = 2'b10; push(2'b01, 1'b0, 6); push(2'b10, 1'b0, 13);
        wait_ack(20);
        wait_ack(20);
        chk("cont2_q", q_fb, 1);
        @(negedge clk);

        stuck = 1'b1;
        repeat (3) @(negedge clk);
        req = 2'b01; op = 2'b01; push(2'b01, 1'b1, 6);
        wait_ack(20);
        chk("stuck_sticky", err_sticky, 1);
        @(negedge clk); chk("err_one_cycle", err, 0); chk("sticky_hold", err_sticky, 1);
        stuck = 1'b0;
        repeat (4) @(negedge clk);
        chk("sticky_hold2", err_sticky, 1);

        req = 2'b10; op = 2'b00;
        @(negedge clk); chk("pre_rst_r_n", r_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_s_n", s_n, 1);
        chk("mid_rst_r_n", r_n, 1);
        chk("mid_rst_busy", busy, 0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_clears_sticky", err_sticky, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", ack, 0);
        end

        req = 2'b01; op = 2'b01; push(2'b01, 1'b0, 6);
        wait_ack(20);
        repeat (2) @(negedge clk);
        req = 2'b01; op = 2'b01; push(2'b01, 1'b0, RED_LAT);
        @(negedge clk); chk("redundant_s_n", s_n, (RED_LAT == 1) ? 32'd1 : 32'd0);
        wait_ack(20);
        chk("redundant_q", q_fb, 1);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
